// File: rtl/seg_p2s_tx_if.sv
// Handshake and serial-link bundle for seg_p2s_tx.
// master: display-controller side (drives start/data, observes status and link).
// slave : transmitter side (consumes start/data, drives status and link).
interface seg_p2s_tx_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  start;
  logic [DATA_WIDTH-1:0] data;
  logic                  busy;
  logic                  done;
  logic                  s_clk;
  logic                  s_out;
  logic                  s_load;

  modport master (
    output start, data,
    input  busy, done, s_clk, s_out, s_load
  );

  modport slave (
    input  start, data,
    output busy, done, s_clk, s_out, s_load
  );
endinterface

// File: rtl/seg_p2s_tx.sv
// seg_p2s_tx: parallel-to-serial transmitter for a serial-in display shift
// register chain. Captures a DATA_WIDTH frame on start, shifts it out with a
// generated serial clock (low CLK_DIV cycles, high CLK_DIV cycles per bit),
// then raises s_load for CLK_DIV cycles and pulses done.
// Optional build macro: SEG_P2S_LSB_FIRST_EN -- transmit LSB first (shift right)
// for panels wired in reverse chain order. Timing is identical in both builds.
module seg_p2s_tx #(
  parameter int DATA_WIDTH = 64,
  parameter int CLK_DIV    = 2
) (
  input logic         clk,
  input logic         rst_n,
  seg_p2s_tx_if.slave bus
);

  localparam int BIT_W = $clog2(DATA_WIDTH);
  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  state_t                state_q,   state_d;
  logic [DATA_WIDTH-1:0] shift_q,   shift_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic                  busy_q,    busy_d;
  logic                  done_q,    done_d;
  logic                  s_clk_q,   s_clk_d;
  logic                  s_out_q,   s_out_d;
  logic                  s_load_q,  s_load_d;

  // Bit presented on s_out when a new frame is accepted.
  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] d);
`ifdef SEG_P2S_LSB_FIRST_EN
    return d[0];
`else
    return d[DATA_WIDTH-1];
`endif
  endfunction

  // Bit presented on s_out after the shifter advances by one position.
  function automatic logic next_bit(input logic [DATA_WIDTH-1:0] s);
`ifdef SEG_P2S_LSB_FIRST_EN
    return s[1];
`else
    return s[DATA_WIDTH-2];
`endif
  endfunction

  // Advance the shifter one position toward the transmit end.
  function automatic logic [DATA_WIDTH-1:0] shift_step(input logic [DATA_WIDTH-1:0] s);
`ifdef SEG_P2S_LSB_FIRST_EN
    return {1'b0, s[DATA_WIDTH-1:1]};
`else
    return {s[DATA_WIDTH-2:0], 1'b0};
`endif
  endfunction

  // Next-state and next-output logic for the IDLE/SHIFT/LATCH sequencer.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    s_clk_d   = s_clk_q;
    s_out_d   = s_out_q;
    s_load_d  = s_load_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d   = ST_SHIFT;
          shift_d   = bus.data;
          s_out_d   = first_bit(bus.data);
          bit_cnt_d = {BIT_W{1'b0}};
          div_cnt_d = {DIV_W{1'b0}};
          busy_d    = 1'b1;
          s_clk_d   = 1'b0;
        end else begin
          busy_d = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = {DIV_W{1'b0}};
          if (!s_clk_q) begin
            // End of the low phase: rising edge, receiver samples s_out.
            s_clk_d = 1'b1;
          end else if (bit_cnt_q == BIT_LAST) begin
            // Last bit clocked: park the link and raise the latch strobe.
            s_clk_d  = 1'b0;
            s_out_d  = 1'b0;
            s_load_d = 1'b1;
            state_d  = ST_LATCH;
          end else begin
            // Falling edge: present the next bit while s_clk is low.
            s_clk_d   = 1'b0;
            shift_d   = shift_step(shift_q);
            s_out_d   = next_bit(shift_q);
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      ST_LATCH: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = {DIV_W{1'b0}};
          s_load_d  = 1'b0;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      default: begin
        state_d  = ST_IDLE;
        busy_d   = 1'b0;
        s_clk_d  = 1'b0;
        s_out_d  = 1'b0;
        s_load_d = 1'b0;
      end
    endcase
  end

  // State, datapath and registered outputs; reset aborts any frame at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      shift_q   <= {DATA_WIDTH{1'b0}};
      bit_cnt_q <= {BIT_W{1'b0}};
      div_cnt_q <= {DIV_W{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      s_clk_q   <= 1'b0;
      s_out_q   <= 1'b0;
      s_load_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      s_clk_q   <= s_clk_d;
      s_out_q   <= s_out_d;
      s_load_q  <= s_load_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.s_clk  = s_clk_q;
  assign bus.s_out  = s_out_q;
  assign bus.s_load = s_load_q;

endmodule
